// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the core/memory view.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     i_req;
  logic [ADDRESS_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0]    i_rdata;
  logic                     i_valid;
  logic                     d_req;
  logic                     d_we;
  logic [ADDRESS_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0]    d_wdata;
  logic [DATA_WIDTH-1:0]    d_rdata;
  logic                     d_valid;
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     stall_f;
  logic                     stall_m;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_valid, d_rdata, d_valid,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_valid, d_rdata, d_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (I) and load/store (D), with stalls.
// Defining MEM_ARB_PERF_EN adds saturating stall-cycle counters.
module mem_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_i_cycles,
  output logic [31:0]       perf_stall_d_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_d_q, last_d_d;

  logic                     can_issue_s;
  logic                     grant_i_s;
  logic                     grant_d_s;
  logic                     i_valid_s;
  logic                     d_valid_s;
  logic                     mem_en_s;
  logic                     mem_we_s;
  logic                     stall_f_s;
  logic                     stall_m_s;
  logic [ADDRESS_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0]    mem_wdata_s;
  logic [DATA_WIDTH-1:0]    i_rdata_s;
  logic [DATA_WIDTH-1:0]    d_rdata_s;

  // FSM, latency counter and fairness flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_d_q <= last_d_d;
    end
  end

  // Completion, arbitration, memory drive and stall generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    can_issue_s = 1'b0;
    grant_i_s   = 1'b0;
    grant_d_s   = 1'b0;
    i_valid_s   = 1'b0;
    d_valid_s   = 1'b0;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDRESS_WIDTH{1'b0}};
    mem_wdata_s = {DATA_WIDTH{1'b0}};
    i_rdata_s   = {DATA_WIDTH{1'b0}};
    d_rdata_s   = {DATA_WIDTH{1'b0}};
    stall_f_s   = 1'b0;
    stall_m_s   = 1'b0;

    // Everything, stalls included, reads as zero while reset is held.
    if (rst) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      last_d_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: can_issue_s = 1'b1;
        BUSY_I, BUSY_D: begin
          if (cnt_q == LAT) begin
            can_issue_s = 1'b1;
            state_d     = IDLE;
            i_valid_s   = (state_q == BUSY_I);
            d_valid_s   = (state_q == BUSY_D);
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      // D wins unless it won last time and I is also waiting.
      if (can_issue_s) begin
        grant_d_s = bus.d_req & (~bus.i_req | ~last_d_q);
        grant_i_s = bus.i_req & ~grant_d_s;
      end else begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
      end

      if (grant_d_s) begin
        mem_en_s    = 1'b1;
        mem_we_s    = bus.d_we;
        mem_addr_s  = bus.d_addr;
        mem_wdata_s = bus.d_wdata;
        state_d     = BUSY_D;
        cnt_d       = 4'd1;
        last_d_d    = 1'b1;
      end else if (grant_i_s) begin
        mem_en_s   = 1'b1;
        mem_addr_s = bus.i_addr;
        state_d    = BUSY_I;
        cnt_d      = 4'd1;
        last_d_d   = 1'b0;
      end else begin
        mem_en_s = 1'b0;
      end

      i_rdata_s = i_valid_s ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
      d_rdata_s = d_valid_s ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
      stall_m_s = bus.d_req & ~d_valid_s;
      stall_f_s = (bus.i_req & ~i_valid_s) | stall_m_s;
    end
  end

  assign bus.i_valid   = i_valid_s;
  assign bus.d_valid   = d_valid_s;
  assign bus.i_rdata   = i_rdata_s;
  assign bus.d_rdata   = d_rdata_s;
  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.stall_f   = stall_f_s;
  assign bus.stall_m   = stall_m_s;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_q, perf_i_d;
  logic [31:0] perf_d_q, perf_d_d;

  // Saturating stall-cycle counter next values
  always_comb begin
    perf_i_d = perf_i_q;
    perf_d_d = perf_d_q;
    if (bus.i_req && !i_valid_s && (perf_i_q != 32'hFFFF_FFFF)) begin
      perf_i_d = perf_i_q + 32'd1;
    end else begin
      perf_i_d = perf_i_q;
    end
    if (bus.d_req && !d_valid_s && (perf_d_q != 32'hFFFF_FFFF)) begin
      perf_d_d = perf_d_q + 32'd1;
    end else begin
      perf_d_d = perf_d_q;
    end
  end

  // Stall-cycle counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_q <= 32'd0;
      perf_d_q <= 32'd0;
    end else begin
      perf_i_q <= perf_i_d;
      perf_d_q <= perf_d_d;
    end
  end

  assign perf_stall_i_cycles = perf_i_q;
  assign perf_stall_d_cycles = perf_d_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the F-stage fetch port (I) and the M-stage load/store port (D).
- Generates the pipeline stall signals that freeze the pipeline registers while an access is outstanding.
- Sits between the core pipeline and the memory model.
- Memory has a fixed read latency; at most one access is in flight at a time.

Parameters:
DATA_WIDTH, 32, data bus width
ADDRESS_WIDTH, 32, address bus width
MEM_LATENCY, 2, cycles from issue to rdata valid (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
i_req  input  1  fetch request; held with i_addr stable until i_valid
i_addr  input  ADDRESS_WIDTH  fetch address
i_rdata  output  DATA_WIDTH  fetched instruction; meaningful only when i_valid=1
i_valid  output  1  one-cycle fetch completion pulse
d_req  input  1  load/store request; held with d_* stable until d_valid
d_we  input  1  1=store, 0=load
d_addr  input  ADDRESS_WIDTH  data address
d_wdata  input  DATA_WIDTH  store data
d_rdata  output  DATA_WIDTH  load data; meaningful only when d_valid=1
d_valid  output  1  one-cycle load/store completion pulse
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  memory write enable
mem_addr  output  ADDRESS_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data; valid MEM_LATENCY cycles after mem_en
stall_f  output  1  freeze PC and F/D register
stall_m  output  1  freeze PC, F/D, D/E and E/M registers

Behaviour:
- FSM states:
  - IDLE: no access in flight.
  - BUSY_I: fetch in flight.
  - BUSY_D: data access in flight.
- Latency counter: width 4, counts 1..MEM_LATENCY.
- Issue, cycle T:
  - Applies in IDLE, or in a completion cycle (back-to-back issue).
  - The winner drives mem_en=1 and mem_addr, plus mem_we and mem_wdata for D. Driven combinationally in cycle T.
  - FSM moves to BUSY_I or BUSY_D at T+1.
  - Counter loads 1.
- Completion, cycle T+MEM_LATENCY:
  - Fires when the counter equals MEM_LATENCY.
  - The owner's valid is high for exactly this cycle. i_rdata/d_rdata pass mem_rdata combinationally.
  - Stores also complete after MEM_LATENCY cycles; d_rdata is don't-care.
- Arbitration:
  - D has priority over I (older instruction).
  - Anti-starvation: a last_d flag is set on every D grant and cleared on every I grant.
  - If last_d=1 and both requests are present, I wins.
- Non-owner ports:
  - mem_en=0 whenever nothing is issued.
  - Non-owner valid stays 0.
- Throughput: one access per MEM_LATENCY cycles. The next issue may coincide with the completion cycle.
- Stalls (combinational):
  - stall_m = d_req & ~d_valid.
  - stall_f = (i_req & ~i_valid) | stall_m.
- Requests:
  - A request deasserted before its valid while not yet granted is dropped, with no effect.
  - A request withdrawn after grant is a protocol violation. The access still completes and its valid still pulses.
- Reset:
  - Asynchronous; may arrive mid-access.
  - FSM goes to IDLE, counter to 0, last_d to 0.
  - The in-flight access is abandoned; no valid pulses for it.
  - While rst=1, all outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, i_valid, d_valid, i_rdata, d_rdata, stall_f, stall_m.
  - First issue is possible in the first cycle after rst falls.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_stall_i_cycles [31:0] and perf_stall_d_cycles [31:0].
  - perf_stall_i_cycles counts cycles with i_req & ~i_valid; perf_stall_d_cycles counts cycles with d_req & ~d_valid.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- When undefined: the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single fetch, MEM_LATENCY=2:
  - Stimulus: i_req=1, i_addr=0x100 at T; mem_rdata=0x00500093 at T+2.
  - Response: mem_en=1 at T only; i_valid=1 and i_rdata=0x00500093 at T+2; stall_f=1 in T..T+1, 0 at T+2.
- Simultaneous requests, last_d=0:
  - Stimulus: d_req load 0x2000 and i_req 0x104 at T.
  - Response: D issued at T; d_valid at T+2; I issued at T+2 back-to-back; i_valid at T+4; stall_m=1 in T..T+1.
- Starvation guard:
  - Stimulus: d_req held continuously with i_req continuously.
  - Response: grants alternate D, I, D, I with no two consecutive D grants.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF.
  - Response: mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF for one cycle; d_valid at +2.
- Reset mid-access:
  - Stimulus: assert rst one cycle after a fetch issue.
  - Response: all outputs 0 immediately; no i_valid after release; a fresh request issues in the first post-reset cycle.
- MEM_LATENCY=1 with MEM_ARB_PERF_EN:
  - Stimulus: 5 back-to-back fetches.
  - Response: one i_valid per cycle after the first; perf_stall_i_cycles=1.
